// File: rtl/msp430_pkg.sv
// Shared types and opcode field constants for the MSP430 fetch path.
package msp430_pkg;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_SRC = 2'd1,
        FETCH_DST = 2'd2,
        PRESENT   = 2'd3
    } fetch_state_t;

    // Addressing-mode encodings that pull an extension word.
    localparam logic [1:0] AS_INDEXED   = 2'b01;
    localparam logic [1:0] AS_INDIR_INC = 2'b11;

    // R0 (PC) as @PC+ is immediate mode; R3 is the constant generator and never extends.
    localparam logic [3:0] REG_PC  = 4'd0;
    localparam logic [3:0] REG_CG2 = 4'd3;

    localparam logic [5:0] FMT2_PREFIX = 6'b000100;
    localparam logic [2:0] JMP_PREFIX  = 3'b001;

    // Byte distance between consecutive instruction words.
    localparam logic [15:0] WORD_STEP = 16'd2;

endpackage

// File: rtl/ext_len_decode.sv
// Minimal opcode decode: only what is needed to know how many extension
// words follow the opcode, plus flagging the unused 000x opcode space.
module ext_len_decode
    import msp430_pkg::*;
(
    input  logic [15:0] OPCODE,
    output logic        HAS_SRC,
    output logic        HAS_DST,
    output logic        ILLEGAL
);

    logic       fmt1;
    logic       fmt2;
    logic       jmp;
    logic [1:0] as_mode;
    logic [3:0] src_reg;
    logic       unused_opcode;

    // Bit 6 (B/W) has no bearing on instruction length.
    assign unused_opcode = OPCODE[6];

    // Classify the format, then derive extension needs from As/src/Ad.
    always_comb begin
        fmt1    = (OPCODE[15:14] != 2'b00);
        fmt2    = (OPCODE[15:10] == FMT2_PREFIX);
        jmp     = (OPCODE[15:13] == JMP_PREFIX);
        as_mode = OPCODE[5:4];
        src_reg = fmt1 ? OPCODE[11:8] : OPCODE[3:0];

        HAS_SRC = 1'b0;
        HAS_DST = 1'b0;
        ILLEGAL = !(fmt1 || fmt2 || jmp);

        if (fmt1 || fmt2) begin
            HAS_SRC = ((as_mode == AS_INDEXED)   && (src_reg != REG_CG2)) ||
                      ((as_mode == AS_INDIR_INC) && (src_reg == REG_PC));
        end
        if (fmt1) begin
            HAS_DST = OPCODE[7];
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads the opcode word and its
// 0-2 extension words, then holds the assembled instruction for the decoder.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  FETCH_OP  | reading opcode word at PC, latch IR and length flags
//  FETCH_SRC | reading source extension word into EXT_SRC
//  FETCH_DST | reading destination extension word into EXT_DST
//  PRESENT   | no memory request; INSTR_VALID high until INSTR_ACK
//
// A jump from execute overrides everything, including a read completing in
// the same cycle, so a half-fetched instruction is simply abandoned.
module fetch_sequencer
    import msp430_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          AW       = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    output logic          MEM_RD,
    output logic [AW-1:0] MEM_ADDR,
    input  logic [AW-1:0] MEM_RDATA,
    input  logic          MEM_RDY,
    input  logic          JMPE,
    input  logic [AW-1:0] JMP_ADDR,
    output logic [AW-1:0] IR,
    output logic [AW-1:0] EXT_SRC,
    output logic [AW-1:0] EXT_DST,
    output logic          HAS_SRC,
    output logic          HAS_DST,
    output logic          ILLEGAL,
    output logic          INSTR_VALID,
    input  logic          INSTR_ACK,
    output logic [AW-1:0] PC
);

    fetch_state_t state_q, state_d;
    logic [15:0]  pc_q;
    logic [15:0]  ir_q;
    logic [15:0]  ext_src_q;
    logic [15:0]  ext_dst_q;
    logic         has_src_q;
    logic         has_dst_q;
    logic         illegal_q;
    logic         mem_rd_q;
    logic         mem_rd_d;
    logic         capture;
    logic         dec_has_src;
    logic         dec_has_dst;
    logic         dec_illegal;

    ext_len_decode u_ext_len_decode (
        .OPCODE  (MEM_RDATA),
        .HAS_SRC (dec_has_src),
        .HAS_DST (dec_has_dst),
        .ILLEGAL (dec_illegal)
    );

    // A read completes only while we are actually requesting; a jump discards it.
    assign capture = mem_rd_q && MEM_RDY && !JMPE;

    // Next-state selection; the request line follows the next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH_OP: begin
                if (capture) begin
                    if (dec_has_src)      state_d = FETCH_SRC;
                    else if (dec_has_dst) state_d = FETCH_DST;
                    else                  state_d = PRESENT;
                end
            end
            FETCH_SRC: begin
                if (capture) state_d = has_dst_q ? FETCH_DST : PRESENT;
            end
            FETCH_DST: begin
                if (capture) state_d = PRESENT;
            end
            PRESENT: begin
                if (INSTR_ACK) state_d = FETCH_OP;
            end
            default: state_d = FETCH_OP;
        endcase
        if (JMPE) state_d = FETCH_OP;
        mem_rd_d = (state_d != PRESENT);
    end

    // State, registered read request, PC and instruction capture registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= FETCH_OP;
            mem_rd_q  <= 1'b0;
            pc_q      <= RESET_PC & 16'hFFFE;
            ir_q      <= 16'h0000;
            ext_src_q <= 16'h0000;
            ext_dst_q <= 16'h0000;
            has_src_q <= 1'b0;
            has_dst_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_rd_q <= mem_rd_d;
            if (JMPE) begin
                pc_q      <= JMP_ADDR & 16'hFFFE;
                has_src_q <= 1'b0;
                has_dst_q <= 1'b0;
                illegal_q <= 1'b0;
            end else if (capture) begin
                pc_q <= pc_q + WORD_STEP;
                unique case (state_q)
                    FETCH_OP: begin
                        ir_q      <= MEM_RDATA;
                        has_src_q <= dec_has_src;
                        has_dst_q <= dec_has_dst;
                        illegal_q <= dec_illegal;
                    end
                    FETCH_SRC: ext_src_q <= MEM_RDATA;
                    FETCH_DST: ext_dst_q <= MEM_RDATA;
                    default: ;
                endcase
            end
        end
    end

    assign MEM_RD      = mem_rd_q;
    assign MEM_ADDR    = pc_q;
    assign PC          = pc_q;
    assign IR          = ir_q;
    assign EXT_SRC     = ext_src_q;
    assign EXT_DST     = ext_dst_q;
    assign HAS_SRC     = has_src_q;
    assign HAS_DST     = has_dst_q;
    assign ILLEGAL     = illegal_q;
    assign INSTR_VALID = (state_q == PRESENT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a word-addressed memory model.
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        MEM_RD;
    logic [15:0] MEM_ADDR;
    logic [15:0] MEM_RDATA;
    logic        MEM_RDY;
    logic        JMPE;
    logic [15:0] JMP_ADDR;
    logic [15:0] IR;
    logic [15:0] EXT_SRC;
    logic [15:0] EXT_DST;
    logic        HAS_SRC;
    logic        HAS_DST;
    logic        ILLEGAL;
    logic        INSTR_VALID;
    logic        INSTR_ACK;
    logic [15:0] PC;

    logic [15:0] mem [0:32767];
    int          checks   = 0;
    int          failures = 0;

    always #5 CLK = ~CLK;

    assign MEM_RDATA = mem[MEM_ADDR[15:1]];

    fetch_sequencer #(.RESET_PC(16'h0000), .AW(16)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .MEM_RD      (MEM_RD),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_RDATA   (MEM_RDATA),
        .MEM_RDY     (MEM_RDY),
        .JMPE        (JMPE),
        .JMP_ADDR    (JMP_ADDR),
        .IR          (IR),
        .EXT_SRC     (EXT_SRC),
        .EXT_DST     (EXT_DST),
        .HAS_SRC     (HAS_SRC),
        .HAS_DST     (HAS_DST),
        .ILLEGAL     (ILLEGAL),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_ACK   (INSTR_ACK),
        .PC          (PC)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (INSTR_VALID !== 1'b1 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("valid_within_budget", {15'd0, INSTR_VALID}, 16'h0001);
    endtask

    task automatic check_instr(input string tag, input logic [15:0] ir_e,
                               input logic hs_e, input logic hd_e, input logic il_e,
                               input logic [15:0] src_e, input logic [15:0] dst_e,
                               input logic [15:0] pc_e);
        wait_valid(20);
        chk({tag, "_ir"},      IR, ir_e);
        chk({tag, "_has_src"}, {15'd0, HAS_SRC}, {15'd0, hs_e});
        chk({tag, "_has_dst"}, {15'd0, HAS_DST}, {15'd0, hd_e});
        chk({tag, "_illegal"}, {15'd0, ILLEGAL}, {15'd0, il_e});
        chk({tag, "_ext_src"}, EXT_SRC, src_e);
        chk({tag, "_ext_dst"}, EXT_DST, dst_e);
        chk({tag, "_pc"},      PC, pc_e);
    endtask

    task automatic ack_instr();
        INSTR_ACK = 1'b1;
        @(negedge CLK);
        INSTR_ACK = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[16'h0000 >> 1] = 16'h4304;   // MOV R3,R4
        mem[16'h0002 >> 1] = 16'h40B2;   // MOV #1234,&0200
        mem[16'h0004 >> 1] = 16'h1234;
        mem[16'h0006 >> 1] = 16'h0200;
        mem[16'h0008 >> 1] = 16'h1290;   // CALL x(PC)
        mem[16'h000A >> 1] = 16'h0010;
        mem[16'h000C >> 1] = 16'h4292;   // MOV &x,&y (R2 indexed extends)
        mem[16'h000E >> 1] = 16'h1111;
        mem[16'h0010 >> 1] = 16'h2222;
        mem[16'h0012 >> 1] = 16'h4335;   // MOV #-1,R5 via constant generator
        mem[16'h0014 >> 1] = 16'h4034;   // MOV #imm,R4
        mem[16'h0016 >> 1] = 16'hABCD;
        mem[16'h0018 >> 1] = 16'h0000;   // unused opcode space
        mem[16'h001A >> 1] = 16'h40B2;
        mem[16'h001C >> 1] = 16'h5555;
        mem[16'h001E >> 1] = 16'h6666;
        mem[16'h0100 >> 1] = 16'h4304;
        mem[16'hFFFE >> 1] = 16'h3C00;   // JMP

        RST_N = 1'b0; MEM_RDY = 1'b1; JMPE = 1'b0; JMP_ADDR = 16'h0000; INSTR_ACK = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_mem_rd", {15'd0, MEM_RD}, 16'h0000);
        chk("rst_valid",  {15'd0, INSTR_VALID}, 16'h0000);
        chk("rst_pc",     PC, 16'h0000);
        chk("rst_ir",     IR, 16'h0000);
        chk("rst_ext_src", EXT_SRC, 16'h0000);
        chk("rst_flags",  {13'd0, HAS_SRC, HAS_DST, ILLEGAL}, 16'h0000);

        RST_N = 1'b1;
        #1 chk("rel_mem_rd_low", {15'd0, MEM_RD}, 16'h0000);
        @(negedge CLK);
        chk("first_mem_rd",   {15'd0, MEM_RD}, 16'h0001);
        chk("first_mem_addr", MEM_ADDR, 16'h0000);

        check_instr("mov_r3", 16'h4304, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0002);
        chk("present_no_rd", {15'd0, MEM_RD}, 16'h0000);
        ack_instr();
        chk("after_ack_valid", {15'd0, INSTR_VALID}, 16'h0000);
        chk("after_ack_addr",  MEM_ADDR, 16'h0002);

        check_instr("mov_imm_abs", 16'h40B2, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0200, 16'h0008);
        repeat (2) @(negedge CLK);
        chk("hold_valid", {15'd0, INSTR_VALID}, 16'h0001);
        chk("hold_ir",    IR, 16'h40B2);
        chk("hold_pc",    PC, 16'h0008);

        MEM_RDY = 1'b0;
        ack_instr();
        for (int i = 0; i < 3; i++) begin
            chk("stall_addr", MEM_ADDR, 16'h0008);
            chk("stall_rd",   {15'd0, MEM_RD}, 16'h0001);
            chk("stall_valid", {15'd0, INSTR_VALID}, 16'h0000);
            @(negedge CLK);
        end
        MEM_RDY = 1'b1;
        check_instr("call_idx", 16'h1290, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0200, 16'h000C);
        ack_instr();
        chk("call_valid_once", {15'd0, INSTR_VALID}, 16'h0000);

        check_instr("r2_abs", 16'h4292, 1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222, 16'h0012);
        ack_instr();
        check_instr("cg_r3", 16'h4335, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222, 16'h0014);
        ack_instr();
        check_instr("imm_src", 16'h4034, 1'b1, 1'b0, 1'b0, 16'hABCD, 16'h2222, 16'h0018);
        ack_instr();
        check_instr("illegal", 16'h0000, 1'b0, 1'b0, 1'b1, 16'hABCD, 16'h2222, 16'h001A);
        ack_instr();

        // Opcode fetch at 001A completes at the next edge; then we sit in FETCH_SRC.
        chk("jmp_pre_addr", MEM_ADDR, 16'h001A);
        @(negedge CLK);
        chk("jmp_src_addr", MEM_ADDR, 16'h001C);
        chk("jmp_src_flag", {15'd0, HAS_SRC}, 16'h0001);
        JMPE = 1'b1; JMP_ADDR = 16'h0101;
        @(negedge CLK);
        JMPE = 1'b0;
        chk("jmp_addr",     MEM_ADDR, 16'h0100);
        chk("jmp_rd",       {15'd0, MEM_RD}, 16'h0001);
        chk("jmp_valid",    {15'd0, INSTR_VALID}, 16'h0000);
        chk("jmp_drop_src", EXT_SRC, 16'hABCD);
        chk("jmp_flags",    {13'd0, HAS_SRC, HAS_DST, ILLEGAL}, 16'h0000);

        check_instr("at_0100", 16'h4304, 1'b0, 1'b0, 1'b0, 16'hABCD, 16'h2222, 16'h0102);
        JMPE = 1'b1; JMP_ADDR = 16'hFFFF; INSTR_ACK = 1'b1;
        @(negedge CLK);
        JMPE = 1'b0; INSTR_ACK = 1'b0;
        chk("jmp_ack_addr",  MEM_ADDR, 16'hFFFE);
        chk("jmp_ack_valid", {15'd0, INSTR_VALID}, 16'h0000);

        check_instr("wrap_jmp", 16'h3C00, 1'b0, 1'b0, 1'b0, 16'hABCD, 16'h2222, 16'h0000);
        MEM_RDY = 1'b0;
        ack_instr();
        chk("wrap_next_addr", MEM_ADDR, 16'h0000);
        chk("wrap_next_rd",   {15'd0, MEM_RD}, 16'h0001);

        MEM_RDY = 1'b1; JMPE = 1'b1; JMP_ADDR = 16'h0002;
        @(negedge CLK);
        JMPE = 1'b0;
        chk("redir_ir_kept", IR, 16'h3C00);
        chk("redir_addr", MEM_ADDR, 16'h0002);
        repeat (2) @(negedge CLK);
        chk("dst_phase_addr", MEM_ADDR, 16'h0006);
        chk("dst_phase_src",  EXT_SRC, 16'h1234);
        MEM_RDY = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        chk("async_rd",    {15'd0, MEM_RD}, 16'h0000);
        chk("async_valid", {15'd0, INSTR_VALID}, 16'h0000);
        chk("async_pc",    PC, 16'h0000);
        chk("async_ir",    IR, 16'h0000);
        chk("async_ext",   EXT_SRC, 16'h0000);
        chk("async_flags", {13'd0, HAS_SRC, HAS_DST, ILLEGAL}, 16'h0000);
        @(negedge CLK);
        MEM_RDY = 1'b1;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("restart_addr", MEM_ADDR, 16'h0000);
        chk("restart_rd",   {15'd0, MEM_RD}, 16'h0001);
        check_instr("restart", 16'h4304, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
